// File: rtl/gps_uart_pkg.sv
// Constants and TX state encodings shared by the GPS UART transmitter and receiver.
package gps_uart_pkg;

  localparam logic [12:0] BAUD_9600_50M = 13'd5208;
  localparam int          DATA_BITS     = 8;

  // PARITY is only reachable when UART_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_ser_if.sv
// Byte-producer side of the UART transmitter: write strobe, data and FIFO status.
interface uart_tx_ser_if;
  logic [7:0] data_in;
  logic       wr_en;
  logic       full;
  logic       busy;
  logic       overflow;

  modport master (
    output data_in,
    output wr_en,
    input  full,
    input  busy,
    input  overflow
  );

  modport slave (
    input  data_in,
    input  wr_en,
    output full,
    output busy,
    output overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Small show-ahead byte FIFO; dout always presents the oldest entry while not empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] din,
  input  logic       rd_en,
  output logic       full,
  output logic       empty,
  output logic [7:0] dout
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        wr_fire;
  logic        rd_fire;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_ser.sv
// 8N1 UART transmitter with byte FIFO; define UART_TX_PARITY_EN for an 8E1 frame.
module uart_tx_ser
  import gps_uart_pkg::*;
#(
  parameter logic [12:0] BAUD       = BAUD_9600_50M,
  parameter int          FIFO_DEPTH = 4,
  parameter int          FIFO_AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_ser_if.slave  bus,
  output logic          tx_done,
  output logic          uart_tx
);

  tx_state_t   state_reg;
  logic [12:0] cnt_reg;
  logic [2:0]  bit_idx_reg;
  logic [7:0]  shift_reg;
  logic        line_reg;
  logic        done_reg;
  logic        overflow_reg;

  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        pop;
  logic        bit_end;

  assign bit_end = (cnt_reg == BAUD - 13'd1);
  // Popping in the last stop clock lets the next start bit follow with no idle gap.
  assign pop     = !fifo_empty &&
                   ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && bit_end));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (bus.wr_en),
    .din   (bus.data_in),
    .rd_en (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign bus.full     = fifo_full;
  assign bus.busy     = (state_reg != ST_IDLE) || !fifo_empty;
  assign bus.overflow = overflow_reg;
  assign tx_done      = done_reg;
  assign uart_tx      = line_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      line_reg     <= 1'b1;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      overflow_reg <= bus.wr_en && fifo_full;
      case (state_reg)
        ST_IDLE: begin
          line_reg <= 1'b1;
          cnt_reg  <= '0;
          if (!fifo_empty) begin
            shift_reg <= fifo_dout;
            line_reg  <= 1'b0;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            line_reg    <= shift_reg[0];
            state_reg   <= ST_DATA;
          end else begin
            cnt_reg <= cnt_reg + 13'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt_reg <= '0;
            if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              line_reg  <= ^shift_reg;
              state_reg <= ST_PARITY;
`else
              line_reg  <= 1'b1;
              state_reg <= ST_STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              line_reg    <= shift_reg[bit_idx_reg + 3'd1];
            end
          end else begin
            cnt_reg <= cnt_reg + 13'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            cnt_reg   <= '0;
            line_reg  <= 1'b1;
            state_reg <= ST_STOP;
          end else begin
            cnt_reg <= cnt_reg + 13'd1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            cnt_reg  <= '0;
            done_reg <= 1'b1;
            if (!fifo_empty) begin
              shift_reg <= fifo_dout;
              line_reg  <= 1'b0;
              state_reg <= ST_START;
            end else begin
              line_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 13'd1;
          end
        end
        default: begin
          cnt_reg   <= '0;
          line_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Bench for uart_tx_ser: compares every line cycle against a frame-level model (short BAUD).
module tb_uart_tx_ser;

  localparam logic [12:0] BAUD  = 13'd16;
  localparam int          B     = 16;
  localparam int          DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * B;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic tx_done;
  logic uart_tx;

  uart_tx_ser_if bus ();

  uart_tx_ser #(
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH),
    .FIFO_AW    (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .tx_done (tx_done),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] wr_bytes  [16];
  int         wr_cnt;
  logic [7:0] exp_bytes [16];
  int         exp_cnt;

  // Expected line level k cycles after the first start bit began.
  function automatic logic exp_line(input int k);
    int         f;
    int         slot;
    logic [7:0] b;
    if (k < 0) return 1'b1;
    f = k / FRAME_CLKS;
    if (f >= exp_cnt) return 1'b1;
    b    = exp_bytes[f];
    slot = (k % FRAME_CLKS) / B;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (FRAME_BITS == 11 && slot == 9) return ^b;
    return 1'b1;
  endfunction

  // Writes wr_bytes on consecutive cycles and checks the whole resulting transmission.
  task automatic run_stream(input string name);
    int   k;
    int   k_end;
    int   ovf_seen;
    int   ovf_exp;
    int   done_seen;
    int   acc;
    int   popped;
    bit   ok_line;
    bit   ok_done;
    bit   ok_busy;
    bit   ok_full;
    logic e_line;
    logic e_done;
    logic e_busy;
    logic e_full;
    ok_line   = 1'b1;
    ok_done   = 1'b1;
    ok_busy   = 1'b1;
    ok_full   = 1'b1;
    ovf_seen  = 0;
    done_seen = 0;
    // The first byte leaves the FIFO one cycle after it lands, so DEPTH+1 fit.
    exp_cnt = (wr_cnt > DEPTH + 1) ? DEPTH + 1 : wr_cnt;
    for (int i = 0; i < exp_cnt; i++) exp_bytes[i] = wr_bytes[i];
    ovf_exp = wr_cnt - exp_cnt;
    k_end   = exp_cnt * FRAME_CLKS + 4;
    for (int t = 0; t <= k_end + 2; t++) begin
      @(negedge clk);
      k      = t - 2;
      e_line = exp_line(k);
      e_done = (k > 0) && (k % FRAME_CLKS == 0) && (k / FRAME_CLKS <= exp_cnt);
      e_busy = (t >= 1) && (k < exp_cnt * FRAME_CLKS);
      acc    = (t < exp_cnt) ? t : exp_cnt;
      popped = (t >= 2) ? (k / FRAME_CLKS + 1) : 0;
      if (popped > exp_cnt) popped = exp_cnt;
      e_full = ((acc - popped) == DEPTH);
      if (ok_line) begin
        total++;
        if (uart_tx !== e_line) begin
          $display("FAIL %s uart_tx k=%0d got=%b want=%b", name, k, uart_tx, e_line);
          bad++;
          ok_line = 1'b0;
        end
      end
      if (ok_done) begin
        total++;
        if (tx_done !== e_done) begin
          $display("FAIL %s tx_done k=%0d got=%b want=%b", name, k, tx_done, e_done);
          bad++;
          ok_done = 1'b0;
        end
      end
      if (ok_busy) begin
        total++;
        if (bus.busy !== e_busy) begin
          $display("FAIL %s busy k=%0d got=%b want=%b", name, k, bus.busy, e_busy);
          bad++;
          ok_busy = 1'b0;
        end
      end
      if (ok_full) begin
        total++;
        if (bus.full !== e_full) begin
          $display("FAIL %s full t=%0d got=%b want=%b", name, t, bus.full, e_full);
          bad++;
          ok_full = 1'b0;
        end
      end
      if (bus.overflow === 1'b1) ovf_seen++;
      if (tx_done === 1'b1) done_seen++;
      bus.wr_en   = (t < wr_cnt);
      bus.data_in = (t < wr_cnt) ? wr_bytes[t] : 8'h00;
    end
    total++;
    if (ovf_seen !== ovf_exp) begin
      $display("FAIL %s overflow_pulses got=%0d want=%0d", name, ovf_seen, ovf_exp);
      bad++;
    end
    total++;
    if (done_seen !== exp_cnt) begin
      $display("FAIL %s tx_done_pulses got=%0d want=%0d", name, done_seen, exp_cnt);
      bad++;
    end
    $display("%s: wrote %0d bytes, expected %0d frames, saw %0d tx_done, %0d overflow",
             name, wr_cnt, exp_cnt, done_seen, ovf_seen);
  endtask

  task automatic test_reset();
    bus.wr_en   = 1'b0;
    bus.data_in = 8'h00;
    reset       = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({uart_tx, bus.busy, bus.full, tx_done, bus.overflow} !== 5'b10000) begin
      $display("FAIL reset_outputs got=%b want=10000",
               {uart_tx, bus.busy, bus.full, tx_done, bus.overflow});
      bad++;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({uart_tx, bus.busy} !== 2'b10) begin
      $display("FAIL post_reset_idle got=%b want=10", {uart_tx, bus.busy});
      bad++;
    end
    $display("reset: line=%b busy=%b", uart_tx, bus.busy);
  endtask

  task automatic test_single();
    wr_bytes[0] = 8'h55;
    wr_cnt      = 1;
    run_stream("single_55");
  endtask

  task automatic test_back_to_back();
    wr_bytes[0] = 8'h41;
    wr_bytes[1] = 8'h54;
    wr_bytes[2] = 8'h0D;
    wr_cnt      = 3;
    run_stream("back_to_back");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) wr_bytes[i] = 8'(8'h10 + i * 8'h13);
    wr_cnt = 6;
    run_stream("overflow");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      wr_cnt = $urandom_range(1, 5);
      for (int i = 0; i < wr_cnt; i++) wr_bytes[i] = 8'($urandom);
      run_stream($sformatf("random_%0d", r));
    end
  endtask

  task automatic test_reset_mid_frame();
    int   k_hit;
    bit   ok;
    k_hit = 3 * B + B / 2;
    for (int t = 0; t < k_hit + 3; t++) begin
      @(negedge clk);
      bus.wr_en   = (t < 2);
      bus.data_in = (t == 0) ? 8'hA3 : 8'h5C;
    end
    @(negedge clk);
    total++;
    if (uart_tx !== 1'b0) begin
      $display("FAIL mid_frame_line_before_reset got=%b want=0", uart_tx);
      bad++;
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if ({uart_tx, bus.busy, bus.full, tx_done} !== 4'b1000) begin
      $display("FAIL mid_frame_async_reset got=%b want=1000",
               {uart_tx, bus.busy, bus.full, tx_done});
      bad++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ok    = 1'b1;
    for (int t = 0; t < 2 * FRAME_CLKS && ok; t++) begin
      @(negedge clk);
      total++;
      if ({uart_tx, tx_done, bus.busy} !== 3'b100) begin
        $display("FAIL after_reset_idle t=%0d got=%b want=100", t,
                 {uart_tx, tx_done, bus.busy});
        bad++;
        ok = 1'b0;
      end
    end
    $display("reset_mid_frame: line=%b busy=%b after release", uart_tx, bus.busy);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    wr_bytes[0] = 8'h07;
    wr_cnt      = 1;
    run_stream("parity_07");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
